// File: rtl/sinc3_pkg.sv
// Shared definitions for the sinc3 decimation filter controller:
// sequencing states and default timing constants.
package sinc3_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } sinc3_state_t;

    localparam int DEF_MCLK_DIV = 4;
    localparam int DEF_DR_LOG2  = 8;
    localparam int DEF_SETTLE   = 4;

endpackage

// File: rtl/sinc3_clkgen.sv
// Modulator clock and decimated word clock generator with the per-word
// capture strobe, all derived from the system clock.
module sinc3_clkgen
    import sinc3_pkg::*;
#(
    parameter int MCLK_DIV = DEF_MCLK_DIV,
    parameter int DR_LOG2  = DEF_DR_LOG2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic start,
    output logic mclk_out,
    output logic word_clk,
    output logic capture
);

    localparam int PW = (MCLK_DIV > 2) ? $clog2(MCLK_DIV) : 1;
    localparam logic [PW-1:0] HALF = PW'(MCLK_DIV / 2);
    localparam logic [PW-1:0] LAST = PW'(MCLK_DIV - 1);

    logic [PW-1:0]      pcnt, pcnt_next;
    logic [DR_LOG2-1:0] mcnt, mcnt_next;
    logic               wrapped, wrapped_next;
    logic               word_next;

    // Outputs are registered from the next-state values so that mclk_out
    // and word_clk change on the same edge as the counters they reflect.
    always_comb begin
        pcnt_next    = '0;
        mcnt_next    = '0;
        wrapped_next = 1'b0;
        if (enable && !start) begin
            pcnt_next    = (pcnt == LAST) ? '0 : pcnt + 1'b1;
            mcnt_next    = mcnt;
            wrapped_next = wrapped;
            if (pcnt_next == HALF) begin
                mcnt_next = mcnt + 1'b1;
                if (mcnt == '1) begin
                    wrapped_next = 1'b1;
                end
            end
        end
        word_next = wrapped_next && (mcnt_next == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt     <= '0;
            mcnt     <= '0;
            wrapped  <= 1'b0;
            mclk_out <= 1'b0;
            word_clk <= 1'b0;
            capture  <= 1'b0;
        end else begin
            pcnt     <= pcnt_next;
            mcnt     <= mcnt_next;
            wrapped  <= wrapped_next;
            mclk_out <= (pcnt_next >= HALF);
            word_clk <= word_next;
            // A disable also drops word_clk but leaves mcnt at 0, so it never strobes.
            capture  <= word_clk && (mcnt_next != '0);
        end
    end

endmodule

// File: rtl/sinc3_ctrl.sv
// Sequencing controller for the sinc3 filter: start/settle/run FSM,
// word capture and valid/ready delivery with sticky overrun.
module sinc3_ctrl
    import sinc3_pkg::*;
#(
    parameter int MCLK_DIV = DEF_MCLK_DIV,
    parameter int DR_LOG2  = DEF_DR_LOG2,
    parameter int WIDTH    = 16,
    parameter int SETTLE   = DEF_SETTLE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             mclk_out,
    output logic             word_clk,
    input  logic [WIDTH-1:0] filter_data,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             running,
    output logic             overrun,
    input  logic             ovr_clr
);

    localparam int SW = $clog2(SETTLE + 1);

    sinc3_state_t state, state_next;
    logic [SW-1:0] settle_cnt;
    logic          capture;
    logic          start;
    logic          active_next;
    logic          run_capture;

    sinc3_clkgen #(
        .MCLK_DIV (MCLK_DIV),
        .DR_LOG2  (DR_LOG2)
    ) u_clkgen (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (active_next),
        .start    (start),
        .mclk_out (mclk_out),
        .word_clk (word_clk),
        .capture  (capture)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Dropping en always wins, even mid-word, so a restart always settles anew.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (en) state_next = ST_SETTLE;
            ST_SETTLE: begin
                if (!en) begin
                    state_next = ST_IDLE;
                end else if (capture && (settle_cnt == SW'(SETTLE - 1))) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN:    if (!en) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
        start       = (state == ST_IDLE) && (state_next == ST_SETTLE);
        active_next = (state_next != ST_IDLE);
        run_capture = (state == ST_RUN) && capture && en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
        end else if (start) begin
            settle_cnt <= '0;
        end else if ((state == ST_SETTLE) && capture && en) begin
            settle_cnt <= settle_cnt + 1'b1;
        end
    end

    // A capture while the consumer is stalled keeps the pending word and flags the loss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            running    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            running <= active_next;
            if (!active_next) begin
                dout_valid <= 1'b0;
            end else if (run_capture && (!dout_valid || dout_ready)) begin
                dout       <= filter_data;
                dout_valid <= 1'b1;
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
            if (run_capture && dout_valid && !dout_ready) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sinc3_ctrl.sv
// Directed bench for sinc3_ctrl with MCLK_DIV=4, DR_LOG2=2, SETTLE=2 and a
// counter standing in for the filter (incremented on each word_clk rise).
module tb_sinc3_ctrl;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             en = 1'b0;
    logic             mclk_out;
    logic             word_clk;
    logic [WIDTH-1:0] filter_data;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready = 1'b0;
    logic             running;
    logic             overrun;
    logic             ovr_clr = 1'b0;

    logic [WIDTH-1:0] model_cnt = '0;
    int               r;
    int               tests = 0;
    int               failures = 0;

    sinc3_ctrl #(
        .MCLK_DIV (4),
        .DR_LOG2  (2),
        .WIDTH    (WIDTH),
        .SETTLE   (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .mclk_out    (mclk_out),
        .word_clk    (word_clk),
        .filter_data (filter_data),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .running     (running),
        .overrun     (overrun),
        .ovr_clr     (ovr_clr)
    );

    always #5 clk = ~clk;

    always @(posedge word_clk) model_cnt <= model_cnt + 1'b1;
    assign filter_data = model_cnt;

    // Expected clock waveforms, r = clk edges since en was sampled high.
    function automatic logic exp_mclk(int rr);
        return (rr % 4) >= 2;
    endfunction

    function automatic logic exp_wclk(int rr);
        return (rr >= 14) && (((rr - 14) % 16) < 4);
    endfunction

    task automatic tick();
        @(posedge clk);
        r = r + 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        tests += 6;
        if (mclk_out !== 1'b0)   begin failures++; $display("[TB] FAIL reset_mclk got %b want 0", mclk_out); end
        if (word_clk !== 1'b0)   begin failures++; $display("[TB] FAIL reset_wclk got %b want 0", word_clk); end
        if (dout !== '0)         begin failures++; $display("[TB] FAIL reset_dout got %h want 0", dout); end
        if (dout_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got %b want 0", dout_valid); end
        if (running !== 1'b0)    begin failures++; $display("[TB] FAIL reset_running got %b want 0", running); end
        if (overrun !== 1'b0)    begin failures++; $display("[TB] FAIL reset_overrun got %b want 0", overrun); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if ({mclk_out, word_clk, dout_valid, running} !== 4'b0) begin
                failures++;
                $display("[TB] FAIL idle_outputs got %b want 0000", {mclk_out, word_clk, dout_valid, running});
            end
        end
    endtask

    task automatic test_clocks_settle();
        en = 1'b1;
        r = -1;
        for (int i = 0; i < 51; i++) begin
            tick();
            tests += 4;
            if (mclk_out !== exp_mclk(r)) begin failures++; $display("[TB] FAIL mclk r=%0d got %b want %b", r, mclk_out, exp_mclk(r)); end
            if (word_clk !== exp_wclk(r)) begin failures++; $display("[TB] FAIL wclk r=%0d got %b want %b", r, word_clk, exp_wclk(r)); end
            if (running !== 1'b1)         begin failures++; $display("[TB] FAIL running r=%0d got %b want 1", r, running); end
            if (dout_valid !== 1'b0)      begin failures++; $display("[TB] FAIL settle_valid r=%0d got %b want 0", r, dout_valid); end
        end
        tick();
        tests += 2;
        if (dout_valid !== 1'b1) begin failures++; $display("[TB] FAIL first_valid r=%0d got %b want 1", r, dout_valid); end
        if (dout !== 16'd3)      begin failures++; $display("[TB] FAIL first_dout got %0d want 3", dout); end
    endtask

    task automatic test_streaming();
        logic vexp;
        dout_ready = 1'b1;
        for (int i = 0; i < 33; i++) begin
            tick();
            vexp = (r == 67) || (r == 83);
            tests += 4;
            if (dout_valid !== vexp)      begin failures++; $display("[TB] FAIL stream_valid r=%0d got %b want %b", r, dout_valid, vexp); end
            if (overrun !== 1'b0)         begin failures++; $display("[TB] FAIL stream_overrun r=%0d got %b want 0", r, overrun); end
            if (mclk_out !== exp_mclk(r)) begin failures++; $display("[TB] FAIL stream_mclk r=%0d got %b want %b", r, mclk_out, exp_mclk(r)); end
            if (word_clk !== exp_wclk(r)) begin failures++; $display("[TB] FAIL stream_wclk r=%0d got %b want %b", r, word_clk, exp_wclk(r)); end
            if (vexp) begin
                tests++;
                if (dout !== WIDTH'(3 + (r - 51) / 16)) begin
                    failures++;
                    $display("[TB] FAIL stream_dout r=%0d got %0d want %0d", r, dout, 3 + (r - 51) / 16);
                end
            end
        end
    endtask

    task automatic test_overrun();
        dout_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick();
            tests += 2;
            if (dout_valid !== (r >= 99)) begin failures++; $display("[TB] FAIL ovr_valid r=%0d got %b want %b", r, dout_valid, r >= 99); end
            if (overrun !== (r >= 115))   begin failures++; $display("[TB] FAIL ovr_flag r=%0d got %b want %b", r, overrun, r >= 115); end
            if (r >= 99) begin
                tests++;
                if (dout !== 16'd6) begin failures++; $display("[TB] FAIL ovr_hold r=%0d got %0d want 6", r, dout); end
            end
        end
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        tests += 2;
        if (overrun !== 1'b0)    begin failures++; $display("[TB] FAIL ovr_clear got %b want 0", overrun); end
        if (dout_valid !== 1'b1) begin failures++; $display("[TB] FAIL ovr_clear_valid got %b want 1", dout_valid); end
        while (r < 130) begin
            tick();
            tests++;
            if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL ovr_cleared r=%0d got %b want 0", r, overrun); end
        end
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        tests += 2;
        if (overrun !== 1'b1) begin failures++; $display("[TB] FAIL ovr_set_priority got %b want 1", overrun); end
        if (dout !== 16'd6)   begin failures++; $display("[TB] FAIL ovr_priority_dout got %0d want 6", dout); end
    endtask

    task automatic test_disable_reenable();
        while (r < 142) begin
            tick();
            tests++;
            if (word_clk !== exp_wclk(r)) begin failures++; $display("[TB] FAIL pre_dis_wclk r=%0d got %b want %b", r, word_clk, exp_wclk(r)); end
        end
        en = 1'b0;
        tick();
        tests += 5;
        if (mclk_out !== 1'b0)   begin failures++; $display("[TB] FAIL dis_mclk got %b want 0", mclk_out); end
        if (word_clk !== 1'b0)   begin failures++; $display("[TB] FAIL dis_wclk got %b want 0", word_clk); end
        if (dout_valid !== 1'b0) begin failures++; $display("[TB] FAIL dis_valid got %b want 0", dout_valid); end
        if (running !== 1'b0)    begin failures++; $display("[TB] FAIL dis_running got %b want 0", running); end
        if (overrun !== 1'b1)    begin failures++; $display("[TB] FAIL dis_overrun got %b want 1", overrun); end
        for (int i = 0; i < 6; i++) begin
            tick();
            tests++;
            if ({mclk_out, word_clk, dout_valid, running} !== 4'b0) begin
                failures++;
                $display("[TB] FAIL dis_idle got %b want 0000", {mclk_out, word_clk, dout_valid, running});
            end
        end
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        tests++;
        if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL dis_ovr_clr got %b want 0", overrun); end
        en = 1'b1;
        r = -1;
        for (int i = 0; i < 51; i++) begin
            tick();
            tests += 3;
            if (dout_valid !== 1'b0)      begin failures++; $display("[TB] FAIL resettle_valid r=%0d got %b want 0", r, dout_valid); end
            if (mclk_out !== exp_mclk(r)) begin failures++; $display("[TB] FAIL resettle_mclk r=%0d got %b want %b", r, mclk_out, exp_mclk(r)); end
            if (word_clk !== exp_wclk(r)) begin failures++; $display("[TB] FAIL resettle_wclk r=%0d got %b want %b", r, word_clk, exp_wclk(r)); end
        end
        tick();
        tests += 2;
        if (dout_valid !== 1'b1) begin failures++; $display("[TB] FAIL resettle_first_valid got %b want 1", dout_valid); end
        if (dout !== 16'd12)     begin failures++; $display("[TB] FAIL resettle_dout got %0d want 12", dout); end
    endtask

    task automatic test_async_reset();
        while (r < 63) tick();
        tests++;
        if (word_clk !== 1'b1) begin failures++; $display("[TB] FAIL pre_reset_wclk got %b want 1", word_clk); end
        #2 rst_n = 1'b0;
        #1;
        tests += 6;
        if (mclk_out !== 1'b0)   begin failures++; $display("[TB] FAIL arst_mclk got %b want 0", mclk_out); end
        if (word_clk !== 1'b0)   begin failures++; $display("[TB] FAIL arst_wclk got %b want 0", word_clk); end
        if (dout !== '0)         begin failures++; $display("[TB] FAIL arst_dout got %h want 0", dout); end
        if (dout_valid !== 1'b0) begin failures++; $display("[TB] FAIL arst_valid got %b want 0", dout_valid); end
        if (running !== 1'b0)    begin failures++; $display("[TB] FAIL arst_running got %b want 0", running); end
        if (overrun !== 1'b0)    begin failures++; $display("[TB] FAIL arst_overrun got %b want 0", overrun); end
        en = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            tests++;
            if ({mclk_out, word_clk, dout_valid, running, dout} !== {4'b0, 16'h0}) begin
                failures++;
                $display("[TB] FAIL post_reset_idle got %b/%h want 0000/0000", {mclk_out, word_clk, dout_valid, running}, dout);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clocks_settle();
        test_streaming();
        test_overrun();
        test_disable_reenable();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
